// File: rtl/dsp48_pkg.sv
// dsp48_pkg: shared FSM states, OPMODE encodings and DSP slice register configuration
package dsp48_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, RESULT} state_t;
    localparam logic [7:0] OPM_FIRST = 8'b0000_0001;
    localparam logic [7:0] OPM_ACC   = 8'b0000_1001;
    localparam logic [7:0] OPM_HOLD  = 8'b0000_1000;
    localparam int A0REG     = 0;
    localparam int A1REG     = 1;
    localparam int B0REG     = 0;
    localparam int B1REG     = 1;
    localparam int MREG      = 1;
    localparam int PREG      = 1;
    localparam int OPMODEREG = 1;
endpackage

// File: rtl/dsp48_opm_align.sv
// dsp48_opm_align: delays {beat-valid, first} from data issue so OPMODE meets its product in the slice
module dsp48_opm_align
    import dsp48_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       beat_v,
    input  logic       beat_first,
    output logic [7:0] opmode
);
    logic [DEPTH-1:0] v_q, v_d, f_q, f_d;
    always_comb begin
        v_d    = (v_q << 1) | DEPTH'(beat_v);
        f_d    = (f_q << 1) | DEPTH'(beat_first);
        opmode = !v_q[DEPTH-1] ? OPM_HOLD : (f_q[DEPTH-1] ? OPM_FIRST : OPM_ACC);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            f_q <= '0;
        end else begin
            v_q <= v_d;
            f_q <= f_d;
        end
    end
endmodule

// File: rtl/dsp48_mac_sequencer.sv
// dsp48_mac_sequencer: command-driven MAC controller sequencing one DSP48 slice into a held result port
module dsp48_mac_sequencer
    import dsp48_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int DSP_LAT = 3
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      in_a,
    input  logic [17:0]      in_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_data,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_ce,
    input  logic [47:0]      dsp_p
);
    localparam int DW = $clog2(DSP_LAT + 1);
    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic             first_q, first_d;
    logic             issue_v_q, issue_v_d, issue_f_q, issue_f_d;
    logic             cmd_ready_q, cmd_ready_d, in_ready_q, in_ready_d, res_valid_q, res_valid_d;
    logic [47:0]      res_data_q, res_data_d;
    logic [17:0]      dsp_a_q, dsp_a_d, dsp_b_q, dsp_b_d;
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        drain_d    = drain_q;
        first_d    = first_q;
        res_data_d = res_data_q;
        dsp_a_d    = dsp_a_q;
        dsp_b_d    = dsp_b_q;
        issue_v_d  = 1'b0;
        issue_f_d  = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid && cmd_ready_q) begin
                if (cmd_len != '0) begin
                    cnt_d   = cmd_len;
                    first_d = 1'b1;
                    state_d = RUN;
                end else begin
                    res_data_d = '0;
                    state_d    = RESULT;
                end
            end
            RUN: if (in_valid && in_ready_q) begin
                dsp_a_d   = in_a;
                dsp_b_d   = in_b;
                issue_v_d = 1'b1;
                issue_f_d = first_q;
                first_d   = 1'b0;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == LEN_W'(1)) begin
                    drain_d = DW'(DSP_LAT);
                    state_d = DRAIN;
                end
            end
            DRAIN: if (drain_q == '0) begin
                res_data_d = dsp_p;
                state_d    = RESULT;
            end else begin
                drain_d = drain_q - 1'b1;
            end
            RESULT: if (res_ready && res_valid_q) state_d = IDLE;
        endcase
        cmd_ready_d = state_d == IDLE;
        in_ready_d  = state_d == RUN;
        res_valid_d = state_d == RESULT;
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            drain_q     <= '0;
            first_q     <= 1'b0;
            issue_v_q   <= 1'b0;
            issue_f_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            dsp_a_q     <= '0;
            dsp_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            first_q     <= first_d;
            issue_v_q   <= issue_v_d;
            issue_f_q   <= issue_f_d;
            cmd_ready_q <= cmd_ready_d;
            in_ready_q  <= in_ready_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            dsp_a_q     <= dsp_a_d;
            dsp_b_q     <= dsp_b_d;
        end
    end
    // issue flags already sit one edge after acceptance, so only DSP_LAT-2 more stages are needed
    dsp48_opm_align #(.DEPTH(DSP_LAT - 2)) u_align (
        .clk       (CLK),
        .rst_n     (RST_N),
        .beat_v    (issue_v_q),
        .beat_first(issue_f_q),
        .opmode    (dsp_opmode)
    );
    assign cmd_ready = cmd_ready_q;
    assign in_ready  = in_ready_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign dsp_a     = dsp_a_q;
    assign dsp_b     = dsp_b_q;
    assign dsp_ce    = RST_N;
endmodule

// File: tb/tb_dsp48_mac_sequencer.sv
// tb_dsp48_mac_sequencer: directed bench with a behavioural DSP48 slice model (A1/B1, M, OPMODE, P registers)
module tb_dsp48_mac_sequencer;
    localparam logic [7:0] HOLD  = 8'b0000_1000;
    localparam logic [7:0] FIRST = 8'b0000_0001;
    localparam logic [7:0] ACC   = 8'b0000_1001;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] in_a = '0;
    logic [17:0] in_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [47:0] res_data;
    logic [17:0] dsp_a, dsp_b;
    logic [7:0]  dsp_opmode;
    logic        dsp_ce;
    logic [47:0] dsp_p;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [17:0] va[8];
    logic [17:0] vb[8];

    dsp48_mac_sequencer dut (
        .CLK(clk), .RST_N(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce), .dsp_p(dsp_p)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // slice model: A1/B1 -> M -> P, with OPMODE registered alongside M
    logic signed [17:0] a1 = '0, b1 = '0;
    logic signed [35:0] prod;
    logic        [47:0] m = '0, p = '0, x_mux, z_mux;
    logic        [7:0]  opm_r = 8'b0000_1000;
    assign prod  = a1 * b1;
    assign x_mux = (opm_r[1:0] == 2'b01) ? m : 48'd0;
    assign z_mux = (opm_r[3:2] == 2'b10) ? p : 48'd0;
    assign dsp_p = p;
    always @(posedge clk) begin
        if (dsp_ce) begin
            a1    <= dsp_a;
            b1    <= dsp_b;
            m     <= {{12{prod[35]}}, prod};
            opm_r <= dsp_opmode;
            p     <= x_mux + z_mux;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int len, output int acc);
        int t;
        cmd_valid = 1'b1;
        cmd_len   = 16'(len);
        t = 0;
        while (cmd_ready !== 1'b1 && t < 30) begin tick(); t++; end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_accept: cmd_ready=%b required 1 within 30 cycles", cmd_ready);
        end
        tick();
        acc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic send_beats(input int n, input int gap, output int last);
        int t;
        last = -1;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_a = va[i];
            in_b = vb[i];
            t = 0;
            while (in_ready !== 1'b1 && t < 30) begin tick(); t++; end
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL beat_accept[%0d]: in_ready=%b required 1 within 30 cycles", i, in_ready);
            end
            tick();
            in_valid = 1'b0;
            last = cyc;
            if (i < n - 1) repeat (gap) tick();
        end
    endtask

    task automatic wait_result(input int budget, output logic [47:0] data, output int edge_n);
        int t;
        t = 0;
        while (res_valid !== 1'b1 && t < budget) begin tick(); t++; end
        n_checks++;
        if (res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL result_wait: res_valid=%b required 1 within %0d cycles", res_valid, budget);
        end
        data   = res_data;
        edge_n = cyc;
    endtask

    task automatic consume;
        res_ready = 1'b1;
        tick();
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL consume: res_valid=%b required 0", res_valid);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({cmd_ready, in_ready, res_valid, dsp_ce} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: {cmd_ready,in_ready,res_valid,dsp_ce}=%b required 0000", {cmd_ready, in_ready, res_valid, dsp_ce});
        end
        n_checks++;
        if (res_data !== 48'd0) begin
            n_fail++;
            $display("FAIL reset_res_data: got %h required 0", res_data);
        end
        n_checks++;
        if ({dsp_a, dsp_b} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_dsp_ab: got a=%h b=%h required 0", dsp_a, dsp_b);
        end
        n_checks++;
        if (dsp_opmode !== HOLD) begin
            n_fail++;
            $display("FAIL reset_opmode: got %b required %b", dsp_opmode, HOLD);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({cmd_ready, dsp_ce} !== 2'b01) begin
            n_fail++;
            $display("FAIL release: {cmd_ready,dsp_ce}=%b required 01", {cmd_ready, dsp_ce});
        end
        tick();
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_ready_rise: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_opmode;
        int acc, e;
        logic [47:0] d;
        res_ready = 1'b1;
        send_cmd(2, acc);
        in_a = 18'd1; in_b = 18'd1; in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (dsp_opmode !== FIRST) begin
            n_fail++;
            $display("FAIL opmode_first: got %b required %b", dsp_opmode, FIRST);
        end
        tick();
        n_checks++;
        if (dsp_opmode !== ACC) begin
            n_fail++;
            $display("FAIL opmode_acc: got %b required %b", dsp_opmode, ACC);
        end
        tick();
        n_checks++;
        if (dsp_opmode !== HOLD) begin
            n_fail++;
            $display("FAIL opmode_hold: got %b required %b", dsp_opmode, HOLD);
        end
        wait_result(20, d, e);
        n_checks++;
        if (d !== 48'd2) begin
            n_fail++;
            $display("FAIL opmode_sum: got %0d required 2", d);
        end
        consume();
    endtask

    task automatic run_sum(input string name, input int n, input int gap, input logic [47:0] exp_v);
        int acc, last, e;
        logic [47:0] d;
        res_ready = 1'b1;
        send_cmd(n, acc);
        send_beats(n, gap, last);
        wait_result(30, d, e);
        n_checks++;
        if (d !== exp_v) begin
            n_fail++;
            $display("FAIL %s_sum: got %h required %h", name, d, exp_v);
        end
        n_checks++;
        if (e - last !== 4) begin
            n_fail++;
            $display("FAIL %s_latency: res_valid at L+%0d required L+4", name, e - last);
        end
        consume();
    endtask

    task automatic test_basic;
        va[0] = 18'd1; va[1] = 18'd2; va[2] = 18'd3; va[3] = 18'd4;
        vb[0] = 18'd5; vb[1] = 18'd6; vb[2] = 18'd7; vb[3] = 18'd8;
        run_sum("basic", 4, 0, 48'd70);
    endtask

    task automatic test_bubbles;
        run_sum("bubbles", 4, 2, 48'd70);
    endtask

    task automatic test_negative;
        va[0] = 18'h3FFFD; vb[0] = 18'd7;
        run_sum("negative", 1, 0, 48'hFFFF_FFFF_FFEB);
    endtask

    task automatic test_zero_len;
        int acc, e;
        logic [47:0] d;
        res_ready = 1'b0;
        send_cmd(0, acc);
        n_checks++;
        if (dsp_opmode !== HOLD || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_quiet: opmode=%b in_ready=%b required %b/0", dsp_opmode, in_ready, HOLD);
        end
        wait_result(2, d, e);
        n_checks++;
        if (d !== 48'd0) begin
            n_fail++;
            $display("FAIL zero_data: got %h required 0", d);
        end
        n_checks++;
        if (e - acc > 2) begin
            n_fail++;
            $display("FAIL zero_latency: %0d cycles required <= 2", e - acc);
        end
        consume();
        n_checks++;
        if (dsp_opmode !== HOLD) begin
            n_fail++;
            $display("FAIL zero_opmode: got %b required %b", dsp_opmode, HOLD);
        end
    endtask

    task automatic test_backpressure;
        int acc, last, e, ce;
        logic [47:0] d;
        res_ready = 1'b0;
        va[0] = 18'd5; vb[0] = 18'd6;
        send_cmd(1, acc);
        send_beats(1, 0, last);
        wait_result(30, d, e);
        n_checks++;
        if (d !== 48'd30) begin
            n_fail++;
            $display("FAIL bp_sum: got %0d required 30", d);
        end
        cmd_valid = 1'b1;
        cmd_len   = 16'd2;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({res_valid, cmd_ready} !== 2'b10 || res_data !== 48'd30) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: res_valid=%b cmd_ready=%b res_data=%0d required 1/0/30", i, res_valid, cmd_ready, res_data);
            end
        end
        consume();
        ce = cyc;
        va[0] = 18'd1; va[1] = 18'd2;
        vb[0] = 18'd1; vb[1] = 18'd2;
        send_cmd(2, acc);
        n_checks++;
        if (acc - ce !== 1) begin
            n_fail++;
            $display("FAIL bp_next_cmd: accepted %0d cycles after consume required 1", acc - ce);
        end
        send_beats(2, 0, last);
        wait_result(30, d, e);
        n_checks++;
        if (d !== 48'd5) begin
            n_fail++;
            $display("FAIL bp_second_sum: got %0d required 5", d);
        end
        consume();
    endtask

    task automatic test_back_to_back;
        int acc[2];
        int k, e;
        logic fire;
        logic [47:0] d;
        res_ready = 1'b1;
        in_a = 18'd1; in_b = 18'd1; in_valid = 1'b1;
        cmd_len = 16'd2; cmd_valid = 1'b1;
        k = 0;
        for (int t = 0; t < 40 && k < 2; t++) begin
            fire = cmd_ready;
            tick();
            if (fire) begin acc[k] = cyc; k++; end
            if (res_valid === 1'b1) begin
                n_checks++;
                if (res_data !== 48'd2) begin
                    n_fail++;
                    $display("FAIL b2b_first_sum: got %0d required 2", res_data);
                end
            end
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (k !== 2) begin
            n_fail++;
            $display("FAIL b2b_accepts: got %0d required 2", k);
        end else begin
            n_checks++;
            if (acc[1] - acc[0] !== 8) begin
                n_fail++;
                $display("FAIL b2b_period: got %0d required 8", acc[1] - acc[0]);
            end
        end
        wait_result(30, d, e);
        in_valid = 1'b0;
        n_checks++;
        if (d !== 48'd2) begin
            n_fail++;
            $display("FAIL b2b_second_sum: got %0d required 2", d);
        end
        consume();
    endtask

    task automatic test_reset_mid_run;
        int acc, last, e;
        logic [47:0] d;
        res_ready = 1'b1;
        va[0] = 18'd9; va[1] = 18'd9; vb[0] = 18'd9; vb[1] = 18'd9;
        send_cmd(4, acc);
        send_beats(2, 0, last);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({cmd_ready, in_ready, res_valid, res_data, dsp_a, dsp_b, dsp_opmode, dsp_ce} !== {3'b000, 48'd0, 36'd0, HOLD, 1'b0}) begin
            n_fail++;
            $display("FAIL midrun_reset: rdy=%b%b%b data=%h a=%h b=%h opm=%b ce=%b required all reset values",
                     cmd_ready, in_ready, res_valid, res_data, dsp_a, dsp_b, dsp_opmode, dsp_ce);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        va[0] = 18'd2; va[1] = 18'd4; vb[0] = 18'd3; vb[1] = 18'd5;
        send_cmd(2, acc);
        send_beats(2, 0, last);
        wait_result(30, d, e);
        n_checks++;
        if (d !== 48'd26) begin
            n_fail++;
            $display("FAIL midrun_sum: got %0d required 26", d);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_opmode();
        test_basic();
        test_bubbles();
        test_negative();
        test_zero_len();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dsp48_mac_sequencer.md
# dsp48_mac_sequencer

Command-driven multiply-accumulate controller that sequences one `DSP_48` slice configured as A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1.

- Accepts a command giving a vector length and a valid/ready stream of signed 18-bit operand pairs.
- Drives A/B/OPMODE into the slice so that P accumulates the sum of products.
- Returns the 48-bit result through a held valid/ready port.
- Sits between the requesting block and the DSP slice, and is the only driver of the slice's data and OPMODE inputs.

## Interface

Parameters:
- `LEN_W`, default 16: width of the command length field.
- `DSP_LAT`, default 3: clock edges from a `dsp_a`/`dsp_b` update to the matching P register update.

Ports:
- `CLK`, in, 1: single clock, rising edge.
- `RST_N`, in, 1: asynchronous, active-low reset.
- `cmd_valid`, in, 1: command request.
- `cmd_ready`, out, 1: command accepted when high together with `cmd_valid`.
- `cmd_len`, in, `LEN_W`: number of operand pairs.
- `in_valid`, in, 1: operand beat valid.
- `in_ready`, out, 1: beat accepted when high together with `in_valid`.
- `in_a`, in, 18: signed operand A.
- `in_b`, in, 18: signed operand B.
- `res_valid`, out, 1: result available.
- `res_ready`, in, 1: result consumed when high together with `res_valid`.
- `res_data`, out, 48: signed accumulated sum.
- `dsp_a`, out, 18: to slice A.
- `dsp_b`, out, 18: to slice B.
- `dsp_opmode`, out, 8: to slice OPMODE.
- `dsp_ce`, out, 1: drives all slice CE inputs.
- `dsp_p`, in, 48: from slice P.

## Operation

- FSM states: IDLE, RUN, DRAIN, RESULT.
- **IDLE**
  - `cmd_ready`=1.
  - On accept with `cmd_len`≠0: load the beat counter with `cmd_len`, set `first`=1, go to RUN.
  - On accept with `cmd_len`=0: `res_data`←0, go to RESULT. No DSP beat is issued.
- **RUN**
  - `in_ready`=1.
  - Each accepted beat registers `in_a`/`in_b` into `dsp_a`/`dsp_b` and decrements the counter.
  - The last beat (counter=1) moves the FSM to DRAIN and loads the drain counter with `DSP_LAT`.
- **OPMODE encoding**, driven one cycle after the data it belongs to:
  - First beat: `8'b00000001` (X=M, Z=0).
  - Later beats: `8'b00001001` (X=M, Z=P).
  - Bubble, i.e. no beat in the aligned slot: `8'b00001000` (X=0, Z=P), so P holds.
  - Idle default: `8'b00001000`.
- **DRAIN**
  - `in_ready`=0.
  - The drain counter decrements each cycle. On reaching 0, capture `res_data`←`dsp_p` and go to RESULT.
- **RESULT**
  - `res_valid`=1 and `res_data` is held stable until `res_ready`; then go to IDLE.
  - `cmd_ready`=0, so no new command is taken before the result is consumed.
- **`dsp_ce`**: 1 whenever `RST_N` is high.
- **Arithmetic**
  - Two's complement throughout.
  - The sum wraps modulo 2^48 inside the slice. No saturation and no overflow flag.
- **Reset values**
  - `cmd_ready`=0, `in_ready`=0, `res_valid`=0.
  - `res_data`=0, `dsp_a`=0, `dsp_b`=0.
  - `dsp_opmode`=`8'b00001000`, `dsp_ce`=0.
  - FSM=IDLE. `cmd_ready` rises the first cycle after reset is released.
- **Reset mid-operation**: aborts immediately. Stale slice state is harmless because every command's first beat uses Z=0.

## Timing

- Let edge L be the acceptance edge of the last beat.
  - The slice P register holds the final sum after edge L+`DSP_LAT`.
  - `res_data` is captured at edge L+`DSP_LAT`+1.
  - `res_valid` is high from that edge onward.
- The OPMODE for the beat accepted at edge k is on `dsp_opmode` between edges k+1 and k+2. This aligns with the slice's OPMODE register and M register.
- Minimum command-to-command period: N + `DSP_LAT` + 3 cycles, with `res_ready` tied high.
- Input bubbles (`in_valid` low) add cycles but never change the result.
- `cmd_valid` is ignored outside IDLE. `in_valid` is ignored outside RUN.

## Structure

- Shared package `dsp48_pkg` holds:
  - `state_t` enum.
  - OPMODE constants: `OPM_FIRST`, `OPM_ACC`, `OPM_HOLD`.
  - Slice register-configuration parameters, also used by the top-level instantiation of the slice.
- One natural sub-module, `dsp48_opm_align`. It is the delay line carrying {beat-valid, first} from data issue to the OPMODE output, with length `DSP_LAT`−2.
- Everything else lives in the top module.

## Test plan

- **Basic sum**: len=4, a=(1,2,3,4), b=(5,6,7,8), no bubbles, `res_ready`=1 → `res_data`=70, `res_valid` at edge L+4.
- **Bubbles**: same vectors with `in_valid` low for 2 cycles between every beat → `res_data`=70.
- **Negative operand**: len=1, a=-3 (18'h3FFFD), b=7 → `res_data`=48'hFFFFFFFFFFEB.
- **Zero length**: len=0 → `res_data`=0 and `res_valid` within 2 cycles. `dsp_opmode` stays `8'b00001000`.
- **Back-pressure**: `res_ready` held low for 5 cycles with a second command pending → `res_data` stable, `cmd_ready`=0. After consumption, the second command is accepted.
- **Reset mid-RUN**: assert `RST_N` low after 2 beats, which forces all outputs to their reset values. Then issue len=2, a=(2,4), b=(3,5) → `res_data`=26.
